ranger_pos_reader: RTL

- Requester/reader side of the Ranger position lookup interface.
- On each frame start, sweeps ranger indices 1..5 over `rangerNum` and captures each returned 20-bit `{hpos,vpos}` word into an internal position table.
- Per pixel, compares the VGA scan coordinate against the table and reports a registered ranger-hit with the ranger's ID.
- Feeds the pixel/colour mux alongside the player and enemy renderers.

---
 rtl/ranger_pos_reader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ranger_pos_reader.sv
// Ranger position reader: sweeps ranger indices into a position table each frame and reports per-pixel sprite hits.
// Latency: slot k captured 2k edges after frame_start; hit/hit_id registered one cycle after hcount/vcount.
// Backpressure: none; frame_start during a sweep is dropped. Define RANGER_RD_DBUF_EN to double-buffer the table.
module ranger_pos_reader #(
  parameter int NUM_RANGERS = 5,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [19:0] position,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [2:0]  rangerNum,
  output logic        busy,
  output logic        sweep_done,
  output logic        hit,
  output logic [2:0]  hit_id
);

  typedef enum logic [1:0] {IDLE, WAIT, CAP} state_t;

  localparam logic [2:0]  LAST_IDX = 3'(NUM_RANGERS);
  localparam logic [10:0] W11      = 11'(SPRITE_W);
  localparam logic [10:0] H11      = 11'(SPRITE_H);

  state_t     state, state_nxt;
  logic [2:0] ranger_num_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic       cap_en;

  // Active table, read by the hit logic.
  logic [9:0] act_x [NUM_RANGERS];
  logic [9:0] act_y [NUM_RANGERS];
  logic [NUM_RANGERS-1:0] act_v;

  logic       hit_nxt;
  logic [2:0] hit_id_nxt;

  // State register and registered sweep outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rangerNum  <= 3'd0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      rangerNum  <= ranger_num_nxt;
      busy       <= busy_nxt;
      sweep_done <= done_nxt;
    end
  end

  // Sweep sequencing: WAIT gives the source a cycle to register position, CAP stores it.
  always_comb begin
    state_nxt      = state;
    ranger_num_nxt = rangerNum;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    cap_en         = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (frame_start) begin
          state_nxt      = WAIT;
          ranger_num_nxt = 3'd1;
          busy_nxt       = 1'b1;
        end
      end
      WAIT: state_nxt = CAP;
      CAP: begin
        cap_en = 1'b1;
        if (rangerNum < LAST_IDX) begin
          state_nxt      = WAIT;
          ranger_num_nxt = rangerNum + 3'd1;
        end else begin
          state_nxt      = IDLE;
          ranger_num_nxt = 3'd0;
          busy_nxt       = 1'b0;
          done_nxt       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RANGER_RD_DBUF_EN
  logic [9:0] shd_x [NUM_RANGERS];
  logic [9:0] shd_y [NUM_RANGERS];
  logic [NUM_RANGERS-1:0] shd_v;
  logic cap_last;

  assign cap_last = cap_en && (rangerNum == LAST_IDX);

  // Shadow table collects the frame being swept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RANGERS; i++) begin
        shd_x[i] <= 10'd0;
        shd_y[i] <= 10'd0;
      end
      shd_v <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < NUM_RANGERS; i++) begin
        if (rangerNum == 3'(i + 1)) begin
          shd_x[i] <= position[19:10];
          shd_y[i] <= position[9:0];
          shd_v[i] <= |position;
        end
      end
    end
  end

  // Publish the whole frame at once; the last slot bypasses the shadow since it lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RANGERS; i++) begin
        act_x[i] <= 10'd0;
        act_y[i] <= 10'd0;
      end
      act_v <= '0;
    end else if (cap_last) begin
      for (int i = 0; i < NUM_RANGERS; i++) begin
        if (rangerNum == 3'(i + 1)) begin
          act_x[i] <= position[19:10];
          act_y[i] <= position[9:0];
          act_v[i] <= |position;
        end else begin
          act_x[i] <= shd_x[i];
          act_y[i] <= shd_y[i];
          act_v[i] <= shd_v[i];
        end
      end
    end
  end
`else
  // Captures go straight into the active table; the hit logic may see a mixed frame mid-sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RANGERS; i++) begin
        act_x[i] <= 10'd0;
        act_y[i] <= 10'd0;
      end
      act_v <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < NUM_RANGERS; i++) begin
        if (rangerNum == 3'(i + 1)) begin
          act_x[i] <= position[19:10];
          act_y[i] <= position[9:0];
          act_v[i] <= |position;
        end
      end
    end
  end
`endif

  // Sprite box test per slot in 11 bits so boxes near 1023 do not wrap; lowest index wins.
  always_comb begin
    hit_nxt    = 1'b0;
    hit_id_nxt = 3'd0;
    for (int i = NUM_RANGERS - 1; i >= 0; i--) begin
      if (act_v[i] &&
          ({1'b0, hcount} >= {1'b0, act_x[i]}) && ({1'b0, hcount} < ({1'b0, act_x[i]} + W11)) &&
          ({1'b0, vcount} >= {1'b0, act_y[i]}) && ({1'b0, vcount} < ({1'b0, act_y[i]} + H11))) begin
        hit_nxt    = 1'b1;
        hit_id_nxt = 3'(i + 1);
      end
    end
  end

  // Register the hit result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit    <= 1'b0;
      hit_id <= 3'd0;
    end else begin
      hit    <= hit_nxt;
      hit_id <= hit_id_nxt;
    end
  end

endmodule
